// File: rtl/instr_align.sv
// Instruction realigner between fetch and decode: splits fetched words into 16-bit
// parcels, reassembles RV32IC instructions and registers one per cycle toward decode.
module instr_align #(
    parameter logic [31:0] RESET_PC = 32'h100
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] f_pc,
    input  logic [31:0] f_instr,
    input  logic        f_valid,
    output logic        f_stall,
    input  logic        d_flush,
    input  logic        d_ready,
    output logic        d_valid,
    output logic [31:0] d_pc,
    output logic [31:0] d_instr,
    output logic        d_is_c
);

    logic [1:0][15:0] parcel;
    logic [1:0]       parcel_is_c;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_parcel
            assign parcel[gi]      = f_instr[16*gi +: 16];
            assign parcel_is_c[gi] = (f_instr[16*gi +: 2] != 2'b11);
        end
    endgenerate

    // IF/ID output register
    logic        d_valid_q, d_valid_d;
    logic [31:0] d_pc_q, d_pc_d;
    logic [31:0] d_instr_q, d_instr_d;
    logic        d_is_c_q, d_is_c_d;

    // Residual parcel: either a whole compressed instruction or the low half of a 32-bit one
    logic        res_valid_q, res_valid_d;
    logic        res_is_c_q, res_is_c_d;
    logic [15:0] res_parcel_q, res_parcel_d;
    logic [31:0] res_pc_q, res_pc_d;

    logic        adv;
    logic        stall_int;
    logic [31:0] hi_pc;

    logic        emit_en;
    logic [31:0] emit_pc;
    logic [31:0] emit_instr;
    logic        emit_c;

    logic        res_load;
    logic [15:0] res_load_parcel;
    logic        res_load_c;
    logic [31:0] res_load_pc;

    assign adv   = ~d_valid_q | d_ready;
    assign hi_pc = f_pc + 32'd2;

    always_comb begin
        stall_int       = ~adv;
        emit_en         = 1'b0;
        emit_pc         = f_pc;
        emit_instr      = f_instr;
        emit_c          = 1'b0;
        res_load        = 1'b0;
        res_load_parcel = parcel[1];
        res_load_c      = parcel_is_c[1];
        res_load_pc     = hi_pc;
        d_valid_d       = d_valid_q;
        res_valid_d     = res_valid_q;

        if (d_flush) begin
            // Redirect wins even over a stalled decode; the incoming word is dropped.
            stall_int   = 1'b0;
            d_valid_d   = 1'b0;
            res_valid_d = 1'b0;
        end else if (adv) begin
            if (res_valid_q && res_is_c_q) begin
                emit_en     = 1'b1;
                emit_pc     = res_pc_q;
                emit_instr  = {16'h0000, res_parcel_q};
                emit_c      = 1'b1;
                res_valid_d = 1'b0;
                stall_int   = 1'b1;
            end else if (f_valid) begin
                if (res_valid_q) begin
                    emit_en    = 1'b1;
                    emit_pc    = res_pc_q;
                    emit_instr = {parcel[0], res_parcel_q};
                    emit_c     = 1'b0;
                    res_load   = 1'b1;
                end else if (!f_pc[1]) begin
                    emit_en = 1'b1;
                    emit_pc = f_pc;
                    if (parcel_is_c[0]) begin
                        emit_instr = {16'h0000, parcel[0]};
                        emit_c     = 1'b1;
                        res_load   = 1'b1;
                    end else begin
                        emit_instr = f_instr;
                        emit_c     = 1'b0;
                    end
                end else begin
                    // Halfword-aligned target: only the upper parcel belongs to the stream.
                    if (parcel_is_c[1]) begin
                        emit_en    = 1'b1;
                        emit_pc    = f_pc;
                        emit_instr = {16'h0000, parcel[1]};
                        emit_c     = 1'b1;
                    end else begin
                        res_load    = 1'b1;
                        res_load_pc = f_pc;
                        d_valid_d   = 1'b0;
                    end
                end
            end else begin
                d_valid_d = 1'b0;
            end

            if (emit_en) begin
                d_valid_d = 1'b1;
            end
            if (res_load) begin
                res_valid_d = 1'b1;
            end
        end
    end

    always_comb begin
        d_pc_d       = d_pc_q;
        d_instr_d    = d_instr_q;
        d_is_c_d     = d_is_c_q;
        res_is_c_d   = res_is_c_q;
        res_parcel_d = res_parcel_q;
        res_pc_d     = res_pc_q;
        if (emit_en) begin
            d_pc_d    = emit_pc;
            d_instr_d = emit_instr;
            d_is_c_d  = emit_c;
        end
        if (res_load) begin
            res_is_c_d   = res_load_c;
            res_parcel_d = res_load_parcel;
            res_pc_d     = res_load_pc;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            d_valid_q    <= 1'b0;
            d_pc_q       <= RESET_PC;
            d_instr_q    <= 32'h0;
            d_is_c_q     <= 1'b0;
            res_valid_q  <= 1'b0;
            res_is_c_q   <= 1'b0;
            res_parcel_q <= 16'h0;
            res_pc_q     <= RESET_PC;
        end else begin
            d_valid_q    <= d_valid_d;
            d_pc_q       <= d_pc_d;
            d_instr_q    <= d_instr_d;
            d_is_c_q     <= d_is_c_d;
            res_valid_q  <= res_valid_d;
            res_is_c_q   <= res_is_c_d;
            res_parcel_q <= res_parcel_d;
            res_pc_q     <= res_pc_d;
        end
    end

    assign f_stall = reset_n & stall_int;
    assign d_valid = d_valid_q;
    assign d_pc    = d_pc_q;
    assign d_instr = d_instr_q;
    assign d_is_c  = d_is_c_q;

endmodule

// File: tb/tb_instr_align.sv
// Directed bench for instr_align: expected instructions are queued when words are
// fetched and compared in order as decode accepts them.
module tb_instr_align;

    logic        clk;
    logic        reset_n;
    logic [31:0] f_pc;
    logic [31:0] f_instr;
    logic        f_valid;
    logic        f_stall;
    logic        d_flush;
    logic        d_ready;
    logic        d_valid;
    logic [31:0] d_pc;
    logic [31:0] d_instr;
    logic        d_is_c;

    instr_align #(.RESET_PC(32'h100)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .f_pc    (f_pc),
        .f_instr (f_instr),
        .f_valid (f_valid),
        .f_stall (f_stall),
        .d_flush (d_flush),
        .d_ready (d_ready),
        .d_valid (d_valid),
        .d_pc    (d_pc),
        .d_instr (d_instr),
        .d_is_c  (d_is_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        is_c;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   passes = 0;
    int   fails  = 0;
    int   st;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [31:0] pc, input logic [31:0] instr, input logic is_c);
        exp_t e;
        e.pc    = pc;
        e.instr = instr;
        e.is_c  = is_c;
        sb.push_back(e);
    endtask

    // One clock: compare any instruction decode accepts this cycle, then advance.
    task automatic step();
        exp_t e;
        #1;
        if (d_valid && d_ready) begin
            chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                $display("xfer pc=%h instr=%h c=%0d (exp pc=%h instr=%h c=%0d)",
                         d_pc, d_instr, d_is_c, e.pc, e.instr, e.is_c);
                chk("d_pc", d_pc, e.pc);
                chk("d_instr", d_instr, e.instr);
                chk("d_is_c", 32'(d_is_c), 32'(e.is_c));
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        f_valid = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    // Present a word and hold it until the aligner takes it; returns stall cycles seen.
    task automatic feed(input logic [31:0] pc, input logic [31:0] w, output int stalls);
        logic done;
        f_pc    = pc;
        f_instr = w;
        f_valid = 1'b1;
        stalls  = 0;
        done    = 1'b0;
        for (int n = 0; n < 20 && !done; n++) begin
            #1;
            done = !f_stall;
            if (!done) stalls++;
            step();
        end
        chk("feed_consumed", 32'(done), 32'd1);
        f_valid = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0;
        f_pc    = 32'h0;
        f_instr = 32'h0;
        f_valid = 1'b0;
        d_flush = 1'b0;
        d_ready = 1'b0;

        #12;
        chk("rst_d_valid", 32'(d_valid), 32'd0);
        chk("rst_d_pc", d_pc, 32'h100);
        chk("rst_d_instr", d_instr, 32'h0);
        chk("rst_d_is_c", 32'(d_is_c), 32'd0);
        chk("rst_f_stall", 32'(f_stall), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        d_ready = 1'b1;
        @(posedge clk);
        #1;

        // Plain 32-bit instruction
        push(32'h100, 32'h00500093, 1'b0);
        feed(32'h100, 32'h00500093, st);
        chk("t1_stalls", 32'(st), 32'd0);

        // Two compressed in one word; the upper one stalls the following fetch once
        push(32'h104, 32'h00000001, 1'b1);
        push(32'h106, 32'h00000001, 1'b1);
        feed(32'h104, 32'h00010001, st);
        chk("t2_stalls", 32'(st), 32'd0);

        // Straddling 32-bit instruction
        push(32'h108, 32'h00000001, 1'b1);
        feed(32'h108, 32'h00930001, st);
        chk("t2_one_stall", 32'(st), 32'd1);
        push(32'h10A, 32'h00500093, 1'b0);
        feed(32'h10C, 32'h00000050, st);
        chk("t3_stalls", 32'(st), 32'd0);

        // Flush drops the buffered parcel and the word presented alongside it
        d_flush = 1'b1;
        f_valid = 1'b1;
        f_pc    = 32'h110;
        f_instr = 32'h00010001;
        step();
        d_flush = 1'b0;
        f_valid = 1'b0;

        // Halfword-aligned target: lower parcel ignored
        push(32'h112, 32'h00000001, 1'b1);
        feed(32'h112, 32'h00010000, st);
        chk("t4_stalls", 32'(st), 32'd0);

        // Halfword target holding the low half of a 32-bit instruction
        feed(32'h116, 32'h00930000, st);
        chk("t4h_stalls", 32'(st), 32'd0);
        push(32'h116, 32'h00500093, 1'b0);
        push(32'h11A, 32'h00000001, 1'b1);
        feed(32'h118, 32'h00010050, st);
        push(32'h11C, 32'h00500093, 1'b0);
        feed(32'h11C, 32'h00500093, st);
        chk("t4c_stalls", 32'(st), 32'd1);

        // Backpressure: outputs frozen and fetch stalled
        d_ready = 1'b0;
        f_pc    = 32'h120;
        f_instr = 32'h00010001;
        f_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_f_stall", 32'(f_stall), 32'd1);
            chk("bp_d_valid", 32'(d_valid), 32'd1);
            chk("bp_d_pc", d_pc, 32'h11C);
            chk("bp_d_instr", d_instr, 32'h00500093);
            @(posedge clk);
            #1;
        end
        d_ready = 1'b1;
        push(32'h120, 32'h00000001, 1'b1);
        push(32'h122, 32'h00000001, 1'b1);
        feed(32'h120, 32'h00010001, st);
        idle(3);

        // Asynchronous reset with the low half of a straddler pending
        feed(32'h200, 32'h00930001, st);
        #1;
        chk("pre_rst_d_valid", 32'(d_valid), 32'd1);
        chk("pre_rst_d_pc", d_pc, 32'h200);
        #1;
        reset_n = 1'b0;
        #1;
        chk("arst_d_valid", 32'(d_valid), 32'd0);
        chk("arst_d_pc", d_pc, 32'h100);
        chk("arst_d_instr", d_instr, 32'h0);
        chk("arst_f_stall", 32'(f_stall), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        push(32'h300, 32'h00500093, 1'b0);
        feed(32'h300, 32'h00500093, st);
        chk("post_rst_stalls", 32'(st), 32'd0);
        idle(2);

        // Flush while decode is stalled, low half pending
        feed(32'h400, 32'h00930001, st);
        d_ready = 1'b0;
        d_flush = 1'b1;
        #1;
        @(posedge clk);
        #1;
        chk("flush_bp_d_valid", 32'(d_valid), 32'd0);
        d_flush = 1'b0;
        d_ready = 1'b1;
        push(32'h500, 32'h00500093, 1'b0);
        feed(32'h500, 32'h00500093, st);
        idle(2);

        // Top of the address space
        push(32'hFFFF_FFFC, 32'h00000001, 1'b1);
        feed(32'hFFFF_FFFC, 32'h00930001, st);
        push(32'hFFFF_FFFE, 32'h00500093, 1'b0);
        push(32'h0000_0002, 32'h00000001, 1'b1);
        feed(32'h0000_0000, 32'h00010050, st);
        idle(3);

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
